clk_gate_ctrl: RTL and testbench

Activity-driven controller that produces the enable for the team's clock-gating cell (clk_gating).
- Watches a functional activity strobe and a wake request.
- Drops the gate enable after a programmable idle window.
- Re-enables the clock on demand, with a settle window and a level req/ack handshake to the requester.
- Runs on the free-running (ungated) clock, upstream of the gating cell.

---
 rtl/clk_gate_pkg.sv | 18 +
 rtl/clk_gate_cnt.sv | 28 ++
 rtl/clk_gate_ctrl.sv | 118 +++++++++++
 tb/tb_clk_gate_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the clock-gate controller.
//   state_t          : controller FSM encoding (RUN/GATED/WAKE; 3 is illegal)
//   STATE_W          : width of the state / debug state port
//   IDLE_CYCLES_DEF  : default idle window before the clock is gated
//   WAKE_CYCLES_DEF  : default settle window after the clock is re-enabled
package clk_gate_pkg;

  localparam int STATE_W         = 2;
  localparam int IDLE_CYCLES_DEF = 8;
  localparam int WAKE_CYCLES_DEF = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } state_t;

endpackage

// File: rtl/clk_gate_cnt.sv
// Up-counter shared by the idle and wake phases of the gate controller.
//   clk, rst  : free-running clock, async active-high reset
//   clr       : synchronous clear (wins over inc)
//   inc       : count enable
//   term_val  : terminal value for the current phase
//   term      : count equals term_val
module clk_gate_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term_val,
  output logic             term
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign term = (cnt == term_val);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Activity-driven enable generator for the clk_gating cell. Runs on the
// free-running clock; gates after IDLE_CYCLES quiet cycles and re-enables on
// act / wake_req / en=0 with a WAKE_CYCLES settle window and level ack.
//   clk, rst      : free-running clock, async active-high reset
//   en            : gating permitted (0 forces the clock on)
//   act           : activity strobe
//   wake_req      : level wake request, held until wake_ack
//   wake_ack      : clock running and settled for the requester
//   gate_en       : registered enable to clk_gating (1 = clock runs)
//   state         : FSM state for debug
//   gated_cycles  : saturating gated-cycle count (CLK_GATE_STATS_EN only)
// Optional feature macro: CLK_GATE_STATS_EN
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int CNT_W       = 8
`ifdef CLK_GATE_STATS_EN
  ,
  parameter int STAT_W      = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               act,
  input  logic               wake_req,
  output logic               wake_ack,
  output logic               gate_en,
  output logic [STATE_W-1:0] state
`ifdef CLK_GATE_STATS_EN
  ,
  output logic [STAT_W-1:0]  gated_cycles
`endif
);

  localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_TERM = CNT_W'(WAKE_CYCLES - 1);

  // Plain vector so an out-of-range encoding is representable and recoverable.
  logic [STATE_W-1:0] state_q;
  state_t             next_state;
  logic               evt;
  logic               cnt_clr, cnt_inc, cnt_term;
  logic [CNT_W-1:0]   term_val;

  // Anything that needs (or forces) the clock running.
  assign evt = act | wake_req | ~en;

  clk_gate_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .term_val (term_val),
    .term     (cnt_term)
  );

  always_comb begin
    next_state = RUN;
    cnt_clr    = 1'b1;
    cnt_inc    = 1'b0;
    term_val   = IDLE_TERM;
    case (state_q)
      RUN: begin
        // An event in the threshold cycle keeps us in RUN (en=0 wins).
        if (!evt && cnt_term) begin
          next_state = GATED;
        end else if (!evt) begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
        end
      end
      GATED: begin
        next_state = evt ? WAKE : GATED;
      end
      WAKE: begin
        // Committed: events here do not restart the settle window.
        term_val = WAKE_TERM;
        if (cnt_term) begin
          next_state = RUN;
        end else begin
          next_state = WAKE;
          cnt_clr    = 1'b0;
          cnt_inc    = 1'b1;
        end
      end
      default: ; // illegal encoding falls back to RUN
    endcase
  end

  // Enable and ack come straight from flops so the latch-based gate never
  // sees a combinational glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      gate_en  <= 1'b1;
      wake_ack <= 1'b0;
    end else begin
      state_q  <= next_state;
      gate_en  <= (next_state != GATED);
      wake_ack <= (next_state == RUN) && wake_req;
    end
  end

  assign state = state_q;

`ifdef CLK_GATE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      gated_cycles <= '0;
    else if (state_q == GATED && gated_cycles != '1)
      gated_cycles <= gated_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (IDLE_CYCLES=8, WAKE_CYCLES=2).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_clk_gate_ctrl;
  import clk_gate_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, act, wake_req;
  logic       wake_ack, gate_en;
  logic [1:0] state;
`ifdef CLK_GATE_STATS_EN
  logic [15:0] gated_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(.IDLE_CYCLES(8), .WAKE_CYCLES(2), .CNT_W(8)
`ifdef CLK_GATE_STATS_EN
    , .STAT_W(16)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .act      (act),
    .wake_req (wake_req),
    .wake_ack (wake_ack),
    .gate_en  (gate_en),
    .state    (state)
`ifdef CLK_GATE_STATS_EN
    , .gated_cycles (gated_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic ge, input logic ak);
    check({tag, ".state"},    32'(state),    32'(st));
    check({tag, ".gate_en"},  32'(gate_en),  32'(ge));
    check({tag, ".wake_ack"}, 32'(wake_ack), 32'(ak));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; act = 1'b0; wake_req = 1'b0;
    tick(2);
    chk_out("reset", 2'd0, 1'b1, 1'b0);
`ifdef CLK_GATE_STATS_EN
    check("reset.gated_cycles", 32'(gated_cycles), 32'd0);
`endif
    rst = 1'b0;

    // Idle entry: act sampled on edge 1, gate_en drops on edge 9.
    act = 1'b1; tick(1); act = 1'b0;
    tick(7);
    chk_out("idle_edge8", 2'd0, 1'b1, 1'b0);
    tick(1);
    chk_out("idle_edge9", 2'd1, 1'b0, 1'b0);

    // Wake by act after 3 extra gated cycles (4 edges seen in GATED).
    tick(3);
    act = 1'b1; tick(1); act = 1'b0;
    chk_out("wake_act_t1", 2'd2, 1'b1, 1'b0);
    tick(1);
    chk_out("wake_act_t2", 2'd2, 1'b1, 1'b0);
    tick(1);
    chk_out("wake_act_t3", 2'd0, 1'b1, 1'b0);
`ifdef CLK_GATE_STATS_EN
    check("stats.gated_cycles", 32'(gated_cycles), 32'd4);
`endif

    // Restart: second act in idle cycle 7 prevents gating.
    act = 1'b1; tick(1); act = 1'b0;
    tick(6);
    act = 1'b1; tick(1); act = 1'b0;
    tick(7);
    chk_out("restart_no_gate", 2'd0, 1'b1, 1'b0);
    tick(1);
    chk_out("restart_gate", 2'd1, 1'b0, 1'b0);

    // Handshake from GATED.
    wake_req = 1'b1;
    tick(1); chk_out("hs_t1", 2'd2, 1'b1, 1'b0);
    tick(1); chk_out("hs_t2", 2'd2, 1'b1, 1'b0);
    tick(1); chk_out("hs_t3", 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("hs_hold.gate_en", 32'(gate_en), 32'd1);
    end
    chk_out("hs_hold_end", 2'd0, 1'b1, 1'b1);
    wake_req = 1'b0;
    tick(1); chk_out("hs_drop", 2'd0, 1'b1, 1'b0);
    tick(6); chk_out("hs_idle7", 2'd0, 1'b1, 1'b0);
    tick(1); chk_out("hs_idle8", 2'd1, 1'b0, 1'b0);

    // en override.
    en = 1'b0;
    tick(1); chk_out("en_t1", 2'd2, 1'b1, 1'b0);
    tick(1); chk_out("en_t2", 2'd2, 1'b1, 1'b0);
    tick(1); chk_out("en_t3", 2'd0, 1'b1, 1'b0);
    tick(50); chk_out("en_50idle", 2'd0, 1'b1, 1'b0);

    // wake_req raised in RUN: ack after one edge.
    wake_req = 1'b1; tick(1); chk_out("run_req", 2'd0, 1'b1, 1'b1);
    wake_req = 1'b0; tick(1); chk_out("run_req_drop", 2'd0, 1'b1, 1'b0);

    // en falls exactly in the threshold cycle: stay RUN.
    en = 1'b1; tick(7);
    en = 1'b0; tick(1); chk_out("en_thresh", 2'd0, 1'b1, 1'b0);
    en = 1'b1; tick(7); chk_out("en_thresh_idle7", 2'd0, 1'b1, 1'b0);
    tick(1); chk_out("en_thresh_gate", 2'd1, 1'b0, 1'b0);

    // Simultaneous act and wake_req: a single 2-cycle WAKE.
    act = 1'b1; wake_req = 1'b1; tick(1); act = 1'b0;
    chk_out("sim_t1", 2'd2, 1'b1, 1'b0);
    tick(1); chk_out("sim_t2", 2'd2, 1'b1, 1'b0);
    tick(1); chk_out("sim_t3", 2'd0, 1'b1, 1'b1);
    wake_req = 1'b0; tick(1); chk_out("sim_drop", 2'd0, 1'b1, 1'b0);
    tick(6); tick(1); chk_out("sim_regate", 2'd1, 1'b0, 1'b0);

    // Illegal encoding recovers to RUN with the clock on.
    force dut.state_q = 2'b11;
    #1 check("illegal.forced", 32'(state), 32'd3);
    tick(1);
    check("illegal.gate_en", 32'(gate_en), 32'd1);
    check("illegal.wake_ack", 32'(wake_ack), 32'd0);
    release dut.state_q;
    tick(1); chk_out("illegal_run", 2'd0, 1'b1, 1'b0);

    // Async reset mid-GATED, observed before the next rising edge.
    act = 1'b1; tick(1); act = 1'b0;
    tick(8); chk_out("pre_rst_gated", 2'd1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("rst_mid_gated", 2'd0, 1'b1, 1'b0);
`ifdef CLK_GATE_STATS_EN
    check("rst.gated_cycles", 32'(gated_cycles), 32'd0);
`endif
    tick(1); rst = 1'b0;

    // Async reset mid-WAKE with a pending request: nothing remembered.
    act = 1'b1; tick(1); act = 1'b0;
    tick(8); chk_out("pre_rst2_gated", 2'd1, 1'b0, 1'b0);
    wake_req = 1'b1; tick(1); chk_out("pre_rst_wake", 2'd2, 1'b1, 1'b0);
    #2 rst = 1'b1; wake_req = 1'b0;
    #1 chk_out("rst_mid_wake", 2'd0, 1'b1, 1'b0);
    tick(1); rst = 1'b0;
    tick(2); chk_out("post_rst_wake", 2'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
